// File: rtl/heap_pq.sv
// -----------------------------------------------------------------------------
// pq_pkg / heap_pq
//
// Purpose:
//   Responder side of the pq_if priority-queue handshake. Entries are kept as a
//   min-key binary heap in a register array; the root (smallest key) is shown
//   on kvo. An accepted command writes the array once, then the FSM re-sorts
//   one heap level per cycle while busy is high.
//
// Optional feature (compile-time macro):
//   PQ_ERR_EN  - adds the sticky err output that flags an enq-only request
//                while full or a deq-only request while empty.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   enq    in   1      enqueue request, sampled only when busy=0
//   deq    in   1      dequeue request, sampled only when busy=0
//   kvi    in   KW+VW  {key,val} to enqueue
//   kvo    out  KW+VW  head entry (min key); valid when ovalid=1
//   ovalid out  1      count!=0 && !busy
//   empty  out  1      count==0
//   full   out  1      count==DEPTH
//   busy   out  1      heap re-sort in progress; commands ignored
//   err    out  1      sticky misuse flag (PQ_ERR_EN only)
// -----------------------------------------------------------------------------

package pq_pkg;
    parameter int KEY_WIDTH = 8;
    parameter int VAL_WIDTH = 8;
endpackage

module heap_pq #(
    parameter int DEPTH = 15,
    parameter int KW    = pq_pkg::KEY_WIDTH,
    parameter int VW    = pq_pkg::VAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic             deq,
    input  logic [KW+VW-1:0] kvi,
    output logic [KW+VW-1:0] kvo,
    output logic             ovalid,
    output logic             empty,
    output logic             full,
    output logic             busy
`ifdef PQ_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int LEVELS = $clog2(DEPTH + 1);
    localparam int CW     = LEVELS;          // count width
    localparam int EW     = KW + VW;         // entry width
    localparam int XW     = LEVELS + 1;      // child index width (2*idx+2)

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SIFT_UP   = 2'd1,
        ST_SIFT_DOWN = 2'd2
    } state_t;

    // Key field of a {key,val} entry; all ordering uses only this field.
    function automatic logic [KW-1:0] key_of(input logic [EW-1:0] e);
        return e[EW-1:VW];
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [EW-1:0]     r_heap [0:DEPTH-1];
    logic [CW-1:0]     r_count;
    logic [LEVELS-1:0] r_idx;

    logic              w_empty;
    logic              w_full;
    logic              w_idle;
    logic              w_acc_enq;
    logic              w_acc_deq;
    logic              w_acc_rep;

    logic [EW-1:0]     w_cur_e;
    logic [LEVELS-1:0] w_idx_m1;
    logic [LEVELS-1:0] w_parent_i;
    logic [EW-1:0]     w_parent_e;
    logic              w_up_swap;

    logic [XW-1:0]     w_left_x;
    logic [XW-1:0]     w_right_x;
    logic [XW-1:0]     w_count_x;
    logic              w_left_ok;
    logic              w_right_ok;
    logic [LEVELS-1:0] w_left_i;
    logic [LEVELS-1:0] w_right_i;
    logic [EW-1:0]     w_left_e;
    logic [EW-1:0]     w_right_e;
    logic [LEVELS-1:0] w_child_i;
    logic [EW-1:0]     w_child_e;
    logic              w_down_swap;

    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_idle  = (r_state == ST_IDLE);

    // enq+deq on an empty heap degrades to a plain enqueue.
    assign w_acc_enq = w_idle && enq && ((!deq && !w_full) || (deq && w_empty));
    assign w_acc_deq = w_idle && deq && !enq && !w_empty;
    assign w_acc_rep = w_idle && deq && enq && !w_empty;

    assign kvo    = r_heap[0];
    assign busy   = !w_idle;
    assign empty  = w_empty;
    assign full   = w_full;
    assign ovalid = !w_empty && w_idle;

    // Sift-up neighbourhood: current node and its parent (idx-1)/2.
    assign w_cur_e    = r_heap[r_idx];
    assign w_idx_m1   = r_idx - LEVELS'(1);
    assign w_parent_i = {1'b0, w_idx_m1[LEVELS-1:1]};
    assign w_parent_e = r_heap[w_parent_i];
    assign w_up_swap  = (r_idx != LEVELS'(0)) && (key_of(w_cur_e) < key_of(w_parent_e));

    // Sift-down neighbourhood: children 2*idx+1 / 2*idx+2, range-checked
    // against count in a widened index so the last level cannot alias.
    assign w_left_x   = {r_idx, 1'b1};
    assign w_right_x  = w_left_x + XW'(1);
    assign w_count_x  = {1'b0, r_count};
    assign w_left_ok  = (w_left_x < w_count_x);
    assign w_right_ok = (w_right_x < w_count_x);

    // Clamp out-of-range child indices to 0 so array reads stay in bounds.
    always_comb begin
        w_left_i  = LEVELS'(0);
        w_right_i = LEVELS'(0);
        if (w_left_ok) begin
            w_left_i = w_left_x[LEVELS-1:0];
        end else begin
            w_left_i = LEVELS'(0);
        end
        if (w_right_ok) begin
            w_right_i = w_right_x[LEVELS-1:0];
        end else begin
            w_right_i = LEVELS'(0);
        end
    end

    assign w_left_e  = r_heap[w_left_i];
    assign w_right_e = r_heap[w_right_i];

    // Pick the smaller child; the left child wins ties.
    always_comb begin
        w_child_i = w_left_i;
        w_child_e = w_left_e;
        if (w_right_ok && (key_of(w_right_e) < key_of(w_left_e))) begin
            w_child_i = w_right_i;
            w_child_e = w_right_e;
        end else begin
            w_child_i = w_left_i;
            w_child_e = w_left_e;
        end
    end

    assign w_down_swap = w_left_ok && (key_of(w_child_e) < key_of(w_cur_e));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave a sift as soon as no swap is needed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_enq) begin
                    w_state_nxt = ST_SIFT_UP;
                end else if (w_acc_deq || w_acc_rep) begin
                    w_state_nxt = ST_SIFT_DOWN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SIFT_UP: begin
                if (w_up_swap) begin
                    w_state_nxt = ST_SIFT_UP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SIFT_DOWN: begin
                if (w_down_swap) begin
                    w_state_nxt = ST_SIFT_DOWN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Heap array, entry count and working index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_heap[i] <= {EW{1'b0}};
            end
            r_count <= CW'(0);
            r_idx   <= LEVELS'(0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_enq) begin
                        r_heap[r_count] <= kvi;
                        r_idx           <= r_count;
                        r_count         <= r_count + CW'(1);
                    end else if (w_acc_deq) begin
                        // Last entry moves to the root, then sifts down.
                        r_heap[0] <= r_heap[r_count - CW'(1)];
                        r_count   <= r_count - CW'(1);
                        r_idx     <= LEVELS'(0);
                    end else if (w_acc_rep) begin
                        r_heap[0] <= kvi;
                        r_idx     <= LEVELS'(0);
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_SIFT_UP: begin
                    if (w_up_swap) begin
                        r_heap[r_idx]      <= w_parent_e;
                        r_heap[w_parent_i] <= w_cur_e;
                        r_idx              <= w_parent_i;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_SIFT_DOWN: begin
                    if (w_down_swap) begin
                        r_heap[r_idx]     <= w_child_e;
                        r_heap[w_child_i] <= w_cur_e;
                        r_idx             <= w_child_i;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                default: begin
                    r_idx <= LEVELS'(0);
                end
            endcase
        end
    end

`ifdef PQ_ERR_EN
    logic w_misuse;
    logic r_err;

    assign w_misuse = w_idle && ((enq && !deq && w_full) || (deq && !enq && w_empty));
    assign err      = r_err;

    // Sticky misuse flag; only the async reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_misuse) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
`endif

endmodule

// File: tb/tb_heap_pq.sv
// -----------------------------------------------------------------------------
// tb_heap_pq: self-checking bench for heap_pq. A reference model (unordered
// list, min found by linear scan) predicts removed items and the next head;
// predictions are queued when a command is driven and popped when the DUT
// shows the corresponding output.
// -----------------------------------------------------------------------------
module tb_heap_pq;

    localparam int KW     = pq_pkg::KEY_WIDTH;
    localparam int VW     = pq_pkg::VAL_WIDTH;
    localparam int EW     = KW + VW;
    localparam int DEPTH  = 15;
    localparam int LEVELS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq;
    logic          deq;
    logic [EW-1:0] kvi;
    logic [EW-1:0] kvo;
    logic          ovalid;
    logic          empty;
    logic          full;
    logic          busy;
`ifdef PQ_ERR_EN
    logic          err;
    logic          m_err;
`endif

    heap_pq #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enq    (enq),
        .deq    (deq),
        .kvi    (kvi),
        .kvo    (kvo),
        .ovalid (ovalid),
        .empty  (empty),
        .full   (full),
        .busy   (busy)
`ifdef PQ_ERR_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int last_lat = 0;

    logic [EW-1:0] mq [$];     // reference model contents
    logic [EW-1:0] rm_q [$];   // expected removed items
    logic [EW-1:0] hd_q [$];   // expected heads after a command settles

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int k, input int v);
        logic [EW-1:0] e;
        e = {KW'(k), VW'(v)};
        return e;
    endfunction

    function automatic int mdl_min();
        int m = 0;
        for (int i = 1; i < mq.size(); i++) begin
            if (mq[i][EW-1:VW] < mq[m][EW-1:VW]) m = i;
        end
        return m;
    endfunction

    // Entry and exit point of every task: 1 time unit after a rising edge.
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic e, input logic d, input logic [EW-1:0] kv);
        bit acc;
        bit takes;
        int n;
        int m;
        logic [EW-1:0] exp_e;
        wait_idle();
        acc   = 1'b0;
        takes = 1'b0;
        if (e && d) begin
            acc = 1'b1;
            if (mq.size() != 0) begin
                takes = 1'b1;
                m = mdl_min();
                rm_q.push_back(mq[m]);
                mq.delete(m);
            end
            mq.push_back(kv);
        end else if (e) begin
            if (mq.size() < DEPTH) begin
                acc = 1'b1;
                mq.push_back(kv);
            end
`ifdef PQ_ERR_EN
            else m_err = 1'b1;
`endif
        end else if (d) begin
            if (mq.size() != 0) begin
                acc   = 1'b1;
                takes = 1'b1;
                m = mdl_min();
                rm_q.push_back(mq[m]);
                mq.delete(m);
            end
`ifdef PQ_ERR_EN
            else m_err = 1'b1;
`endif
        end
        if (acc && mq.size() != 0) hd_q.push_back(mq[mdl_min()]);

        enq = e;
        deq = d;
        kvi = kv;
        if (takes) begin
            exp_e = rm_q.pop_front();
            chk("removed", 32'(kvo), 32'(exp_e));
        end
        @(posedge clk); #1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = {EW{1'b0}};

        if (acc) begin
            chk("busy_rise", 32'(busy), 32'd1);
            n = 0;
            while (busy && n < 16) begin
                n++;
                @(posedge clk); #1;
            end
            last_lat = n;
            chk("lat_bound", 32'(n >= 1 && n <= LEVELS), 32'd1);
        end else begin
            chk("ignored_busy", 32'(busy), 32'd0);
        end

        if (mq.size() != 0) begin
            if (acc) begin
                exp_e = hd_q.pop_front();
                chk("head", 32'(kvo), 32'(exp_e));
            end
            chk("ovalid", 32'(ovalid), 32'd1);
        end else begin
            chk("ovalid", 32'(ovalid), 32'd0);
        end
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
`ifdef PQ_ERR_EN
        chk("err", 32'(err), 32'(m_err));
`endif
    endtask

    int keys2 [8] = '{5, 10, 3, 20, 2, 12, 27, 8};
    int vals2 [8] = '{3, 1, 4, 10, 6, 7, 24, 17};
    int head2 [8] = '{5, 5, 3, 3, 2, 2, 2, 2};
    int keys3 [4] = '{9, 4, 15, 30};
    int vals3 [4] = '{9, 1, 16, 0};
    int hk3   [4] = '{3, 4, 5, 8};
    int hv3   [4] = '{4, 1, 3, 17};
    int keys4 [8] = '{8, 9, 10, 12, 15, 20, 27, 30};

    initial begin
        rst_n = 1'b0;
        enq   = 1'b0;
        deq   = 1'b0;
        kvi   = {EW{1'b0}};
`ifdef PQ_ERR_EN
        m_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_kvo", 32'(kvo), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset in the middle of a sift-down
        issue(1'b1, 1'b0, mk(10, 0));
        issue(1'b1, 1'b0, mk(20, 0));
        issue(1'b1, 1'b0, mk(30, 0));
        issue(1'b1, 1'b0, mk(40, 0));
        deq = 1'b1;
        @(posedge clk); #1;
        deq = 1'b0;
        chk("t1_mid_sift", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_ovalid", 32'(ovalid), 32'd0);
        chk("t1_kvo", 32'(kvo), 32'd0);
        mq.delete();
        rm_q.delete();
        hd_q.delete();
`ifdef PQ_ERR_EN
        chk("t1_err", 32'(err), 32'd0);
        m_err = 1'b0;
`endif
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, mk(7, 7));
        chk("t1_kvo77", 32'(kvo), 32'(mk(7, 7)));
        issue(1'b0, 1'b1, {EW{1'b0}});

        // 2: eight enqueues, head tracked after each
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, mk(keys2[i], vals2[i]));
            if (i == 0) chk("t2_lat_first", 32'(last_lat), 32'd1);
            chk("t2_head_key", 32'(kvo[EW-1:VW]), 32'(head2[i]));
        end
        chk("t2_kvo", 32'(kvo), 32'(mk(2, 6)));
        chk("t2_full", 32'(full), 32'd0);

        // 3: replace-root operations
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, mk(keys3[i], vals3[i]));
            chk("t3_head", 32'(kvo), 32'(mk(hk3[i], hv3[i])));
        end

        // 4: drain in key order
        for (int i = 0; i < 8; i++) begin
            chk("t4_key", 32'(kvo[EW-1:VW]), 32'(keys4[i]));
            issue(1'b0, 1'b1, {EW{1'b0}});
        end
        chk("t4_empty", 32'(empty), 32'd1);

        // 5: fill to capacity with descending keys
        for (int k = 15; k >= 1; k--) begin
            issue(1'b1, 1'b0, mk(k, k));
        end
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_key1", 32'(kvo[EW-1:VW]), 32'd1);
        issue(1'b1, 1'b0, mk(0, 0));
`ifdef PQ_ERR_EN
        chk("t5_err", 32'(err), 32'd1);
`endif
        chk("t5_still1", 32'(kvo[EW-1:VW]), 32'd1);
        issue(1'b1, 1'b1, mk(0, 0));
        chk("t5_key0", 32'(kvo[EW-1:VW]), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, 1'b1, {EW{1'b0}});
        end

        // 6: misuse and enq+deq on an empty heap
        issue(1'b0, 1'b1, {EW{1'b0}});
        issue(1'b1, 1'b1, mk(6, 2));
        chk("t6_kvo", 32'(kvo), 32'(mk(6, 2)));
        chk("t6_lat", 32'(last_lat), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
